// File: rtl/icb_sdp_bram_ctrl.sv
// icb_sdp_bram_ctrl: ICB responder for a simple dual-port BRAM, in-order pipelined responses,
// read-modify-write for byte-masked writes and a 4-entry credit-protected response FIFO.
module icb_sdp_bram_ctrl #(
  parameter int mem_depth = 4096,
  parameter int mem_latency = 2,
  parameter int simulation_delay = 1,
  localparam int AW = $clog2(mem_depth)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   cmd_addr,
  input  logic          cmd_read,
  input  logic [31:0]   cmd_wdata,
  input  logic [3:0]    cmd_wmask,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          wen_a,
  output logic [AW-1:0] addr_a,
  output logic [31:0]   din_a,
  output logic          ren_b,
  output logic [AW-1:0] addr_b,
  input  logic [31:0]   dout_b
);
  if (mem_latency < 1 || mem_latency > 2 || mem_depth < 16 || (mem_depth & (mem_depth - 1)) != 0 || simulation_delay < 0) begin : g_bad_param
    $error("icb_sdp_bram_ctrl: unsupported parameter set");
  end
  typedef enum logic {IDLE, RMW_WAIT} state_t;
  state_t state;
  logic hs, err, part_w, rmw_last, push, pop, rmw_cnt, addr_unused;
  logic [AW-1:0] idx, rmw_addr;
  logic [31:0] rmw_wdata, merged;
  logic [3:0] rmw_mask;
  logic [mem_latency-1:0] tok_v, tok_rd, tok_err;
  logic [32:0] fifo [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  assign addr_unused = ^cmd_addr[1:0];
  assign idx = cmd_addr[AW+1:2];
  assign err = |cmd_addr[31:AW+2];
  assign part_w = ~cmd_read & ~err & (cmd_wmask != 4'h0) & (cmd_wmask != 4'hF);
  // Tokens in flight reserve FIFO slots so a response never finds the FIFO full.
  assign cmd_ready = (state == IDLE) && ($countones(tok_v) + int'(cnt) < 4);
  assign hs = cmd_valid & cmd_ready;
  assign rmw_last = (state == RMW_WAIT) && (rmw_cnt == 1'(mem_latency - 1));
  assign ren_b = hs & ~err & (cmd_read | part_w);
  assign addr_b = idx;
  assign wen_a = (hs & ~err & ~cmd_read & (cmd_wmask == 4'hF)) | rmw_last;
  assign addr_a = rmw_last ? rmw_addr : idx;
  assign din_a = rmw_last ? merged : cmd_wdata;
  for (genvar i = 0; i < 4; i++) begin : g_merge
    assign merged[8*i+:8] = rmw_mask[i] ? rmw_wdata[8*i+:8] : dout_b[8*i+:8];
  end
  assign push = tok_v[mem_latency-1];
  assign pop = rsp_valid & rsp_ready;
  assign rsp_valid = cnt != 3'd0;
  assign {rsp_err, rsp_rdata} = rsp_valid ? fifo[rp] : 33'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rmw_cnt <= 1'b0;
      rmw_addr <= '0;
      rmw_wdata <= '0;
      rmw_mask <= '0;
    end else if (state == IDLE) begin
      if (hs && part_w) begin
        state <= RMW_WAIT;
        rmw_cnt <= 1'b0;
        rmw_addr <= idx;
        rmw_wdata <= cmd_wdata;
        rmw_mask <= cmd_wmask;
      end
    end else begin
      rmw_cnt <= rmw_cnt + 1'b1;
      state <= rmw_last ? IDLE : RMW_WAIT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_v <= '0;
      tok_rd <= '0;
      tok_err <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      tok_v <= (tok_v << 1) | mem_latency'(hs);
      tok_rd <= (tok_rd << 1) | mem_latency'(cmd_read);
      tok_err <= (tok_err << 1) | mem_latency'(err);
      wp <= wp + 2'(push);
      rp <= rp + 2'(pop);
      cnt <= cnt + 3'(push) - 3'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= {tok_err[mem_latency-1], (tok_rd[mem_latency-1] & ~tok_err[mem_latency-1]) ? dout_b : 32'd0};
  end
endmodule

// File: tb/tb_icb_sdp_bram_ctrl.sv
// tb_icb_sdp_bram_ctrl: directed scoreboard bench for icb_sdp_bram_ctrl at mem_latency 2 and 1.
module tb_icb_sdp_bram_ctrl;
  typedef struct packed { logic [32:0] rsp; int cyc; } exp_t;
  logic clk, rst_n, sel, c_read, c_valid, r_ready, chk_lat;
  logic [31:0] c_addr, c_wdata;
  logic [3:0] c_wmask;
  logic rdy0, rv0, err0, wen0, ren0, rdy1, rv1, err1, wen1, ren1;
  logic [31:0] rd0, din0, dout0, q0, rd1, din1, dout1;
  logic [11:0] aa0, ab0, aa1, ab1;
  logic cmd_ready, rsp_valid, rsp_err, wen_a, ren_b;
  logic [31:0] rsp_rdata, din_a;
  logic [11:0] addr_a, addr_b;
  logic [31:0] ram0 [4096];
  logic [31:0] ram1 [4096];
  logic [31:0] gold [2][4096];
  exp_t q[$];
  int n_vec, n_err, cyc, lat, rmw_cyc, last_hs;
  logic [11:0] rmw_ix;
  logic [31:0] rmw_din;
  logic [32:0] last_rsp;

  icb_sdp_bram_ctrl #(.mem_depth(4096), .mem_latency(2), .simulation_delay(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_addr(c_addr), .cmd_read(c_read), .cmd_wdata(c_wdata),
    .cmd_wmask(c_wmask), .cmd_valid(c_valid && !sel), .cmd_ready(rdy0), .rsp_rdata(rd0),
    .rsp_err(err0), .rsp_valid(rv0), .rsp_ready(r_ready && !sel), .wen_a(wen0), .addr_a(aa0),
    .din_a(din0), .ren_b(ren0), .addr_b(ab0), .dout_b(dout0));
  icb_sdp_bram_ctrl #(.mem_depth(4096), .mem_latency(1), .simulation_delay(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_addr(c_addr), .cmd_read(c_read), .cmd_wdata(c_wdata),
    .cmd_wmask(c_wmask), .cmd_valid(c_valid && sel), .cmd_ready(rdy1), .rsp_rdata(rd1),
    .rsp_err(err1), .rsp_valid(rv1), .rsp_ready(r_ready && sel), .wen_a(wen1), .addr_a(aa1),
    .din_a(din1), .ren_b(ren1), .addr_b(ab1), .dout_b(dout1));

  assign cmd_ready = sel ? rdy1 : rdy0;
  assign rsp_valid = sel ? rv1 : rv0;
  assign rsp_err = sel ? err1 : err0;
  assign rsp_rdata = sel ? rd1 : rd0;
  assign wen_a = sel ? wen1 : wen0;
  assign ren_b = sel ? ren1 : ren0;
  assign addr_a = sel ? aa1 : aa0;
  assign addr_b = sel ? ab1 : ab0;
  assign din_a = sel ? din1 : din0;

  // BRAM models: ram0 has a two-stage read pipeline, ram1 a single stage.
  always @(posedge clk) begin
    if (wen0) ram0[aa0] <= din0;
    if (ren0) q0 <= ram0[ab0];
    dout0 <= q0;
    if (wen1) ram1[aa1] <= din1;
    if (ren1) dout1 <= ram1[ab1];
  end

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_rsp_valid"}, 33'(rsp_valid), 33'd0);
    chk({tag, "_rsp_data"}, {rsp_err, rsp_rdata}, 33'd0);
    chk({tag, "_wen_a"}, 33'(wen_a), 33'd0);
    chk({tag, "_ren_b"}, 33'(ren_b), 33'd0);
    chk({tag, "_cmd_ready"}, 33'(cmd_ready), 33'd1);
  endtask

  task automatic step(output bit h);
    exp_t e;
    logic [11:0] ix;
    logic [31:0] w;
    logic oor, part, full, exp_ren, exp_wen, rmw_now;
    #1;
    ix = c_addr[13:2];
    oor = c_addr >= 32'h4000;
    part = !c_read && c_wmask != 4'h0 && c_wmask != 4'hF;
    full = !c_read && c_wmask == 4'hF;
    h = c_valid && cmd_ready;
    rmw_now = cyc == rmw_cyc + lat;
    if (q.size() == 0) chk("no_stale_rsp", 33'(rsp_valid), 33'd0);
    if (rsp_valid && r_ready && q.size() != 0) begin
      e = q.pop_front();
      last_rsp = {rsp_err, rsp_rdata};
      chk("rsp", last_rsp, e.rsp);
      if (e.cyc >= 0) chk("latency", 33'(cyc), 33'(e.cyc));
    end
    exp_ren = h && !oor && (c_read || part);
    exp_wen = (h && !oor && full) || rmw_now;
    chk("ren_b", 33'(ren_b), 33'(exp_ren));
    chk("wen_a", 33'(wen_a), 33'(exp_wen));
    if (exp_ren) chk("addr_b", 33'(addr_b), 33'(ix));
    if (exp_wen) begin
      chk("addr_a", 33'(addr_a), 33'(rmw_now ? rmw_ix : ix));
      chk("din_a", 33'(din_a), 33'(rmw_now ? rmw_din : c_wdata));
    end
    if (cyc > rmw_cyc && cyc <= rmw_cyc + lat + 1) chk("rmw_cmd_ready", 33'(cmd_ready), 33'(cyc == rmw_cyc + lat + 1));
    if (h) begin
      e.rsp = {oor, (c_read && !oor) ? gold[sel][ix] : 32'h0};
      e.cyc = chk_lat ? cyc + lat + 1 : -1;
      q.push_back(e);
      last_hs = cyc;
      if (!c_read && !oor) begin
        w = gold[sel][ix];
        for (int b = 0; b < 4; b++) if (c_wmask[b]) w[8*b+:8] = c_wdata[8*b+:8];
        gold[sel][ix] = w;
        if (part) begin
          rmw_cyc = cyc;
          rmw_ix = ix;
          rmw_din = w;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    bit h;
    h = 0;
    c_read = rd;
    c_addr = a;
    c_wdata = wd;
    c_wmask = m;
    c_valid = 1;
    for (int t = 0; t < 20 && !h; t++) step(h);
    c_valid = 0;
    chk("accept", 33'(h), 33'd1);
  endtask

  task automatic drain();
    bit h;
    for (int t = 0; t < 30 && q.size() != 0; t++) step(h);
    chk("drain", 33'(q.size()), 33'd0);
  endtask

  task automatic rw_scenario();
    int p;
    issue(0, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(1, 32'h10, 32'h0, 4'h0);
    drain();
    chk("read_back", last_rsp, {1'b0, 32'hDEADBEEF});
    issue(0, 32'h20, 32'h11223344, 4'hF);
    issue(0, 32'h20, 32'hAABBCCDD, 4'b0101);
    p = last_hs;
    issue(1, 32'h20, 32'h0, 4'h0);
    chk("pw_next_accept", 33'(last_hs - p), 33'(lat + 1));
    drain();
    chk("pw_data", last_rsp, {1'b0, 32'h11BB33DD});
  endtask

  initial begin
    bit h;
    int n;
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    lat = 2;
    rmw_cyc = -100;
    last_hs = 0;
    last_rsp = '0;
    rst_n = 0;
    sel = 0;
    c_valid = 0;
    c_read = 0;
    c_addr = 0;
    c_wdata = 0;
    c_wmask = 0;
    r_ready = 1;
    chk_lat = 1;
    for (int a = 0; a < 4096; a++) begin
      gold[0][a] = 0;
      gold[1][a] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      reset_chk("reset");
    end
    sel = 0;
    rst_n = 1;
    @(posedge clk);
    #1;
    rw_scenario();
    issue(0, 32'h20, 32'hFFFFFFFF, 4'h0);
    issue(1, 32'h20, 32'h0, 4'h0);
    drain();
    chk("mask0_data", last_rsp, {1'b0, 32'h11BB33DD});
    issue(0, 32'h0, 32'h5A5A5A5A, 4'hF);
    issue(1, 32'h4000, 32'h0, 4'h0);
    drain();
    chk("oor_read", last_rsp, {1'b1, 32'h0});
    issue(0, 32'h4000, 32'h12345678, 4'hF);
    issue(0, 32'h4004, 32'h87654321, 4'b0011);
    issue(1, 32'h0, 32'h0, 4'h0);
    drain();
    chk("oor_no_alias", last_rsp, {1'b0, 32'h5A5A5A5A});
    for (int k = 0; k < 6; k++) issue(0, 32'h100 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 4'hF);
    drain();
    chk_lat = 0;
    r_ready = 0;
    n = 0;
    for (int t = 0; t < 8; t++) begin
      c_read = 1;
      c_addr = 32'h100 + 32'(4 * n);
      c_valid = n < 6;
      step(h);
      if (h) n++;
    end
    c_valid = 0;
    chk("bp_accepted", 33'(n), 33'd4);
    chk("bp_cmd_ready", 33'(cmd_ready), 33'd0);
    r_ready = 1;
    for (int t = 0; t < 20 && n < 6; t++) begin
      c_read = 1;
      c_addr = 32'h100 + 32'(4 * n);
      c_valid = 1;
      step(h);
      if (h) n++;
    end
    c_valid = 0;
    chk("bp_rest_accepted", 33'(n), 33'd6);
    drain();
    chk("bp_last", last_rsp, {1'b0, 32'hC0DE0005});
    chk_lat = 1;
    for (int k = 0; k < 3; k++) issue(1, 32'h100 + 32'(4 * k), 32'h0, 4'h0);
    rst_n = 0;
    #1;
    reset_chk("mid_reset");
    q.delete();
    rmw_cyc = -100;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    reset_chk("post_reset");
    for (int t = 0; t < 6; t++) step(h);
    sel = 1;
    lat = 1;
    rw_scenario();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
